// File: rtl/narrow16to5.sv
// narrow16to5: reduces a register value to a narrow immediate field.
// Signed or unsigned range check, optional saturation, a two-entry
// (primary + skid) valid/ready output buffer and a saturating counter
// of out-of-range inputs.
module narrow16to5 #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_sign,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_fit,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             ovf_clr
);

    // Buffer occupancy is the only control state.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    occ_t r_occ;
    occ_t w_occNext;

    logic             r_inReady;
    logic [OUT_W-1:0] r_primData;
    logic             r_primFit;
    logic [OUT_W-1:0] r_skidData;
    logic             r_skidFit;
    logic [CNT_W-1:0] r_ovfCount;

    logic               w_accept;
    logic               w_drain;
    logic               w_outValid;
    logic               w_loadPrimNew;
    logic               w_loadPrimSkid;
    logic               w_loadSkidNew;
    logic               w_countEvent;

    logic [IN_W-OUT_W:0]   w_signField;
    logic [IN_W-OUT_W-1:0] w_upperField;
    logic                  w_fitSigned;
    logic                  w_fitUnsigned;
    logic                  w_fit;
    logic [OUT_W-1:0]      w_satValue;
    logic [OUT_W-1:0]      w_result;

    // Handshake qualifiers; drain only depends on registered occupancy.
    assign w_accept     = in_valid & r_inReady;
    assign w_drain      = (r_occ != OCC_EMPTY) & out_ready;
    assign w_countEvent = w_accept & ~w_fit;

    // Range check and result selection for the value presented on the input.
    always_comb begin
        w_signField   = in_data[IN_W-1:OUT_W-1];
        w_upperField  = in_data[IN_W-1:OUT_W];
        w_fitSigned   = (&w_signField) | ~(|w_signField);
        w_fitUnsigned = ~(|w_upperField);
        w_fit         = in_sign ? w_fitSigned : w_fitUnsigned;
        if (in_sign) begin
            w_satValue = {in_data[IN_W-1], {(OUT_W-1){~in_data[IN_W-1]}}};
        end else begin
            w_satValue = {OUT_W{1'b1}};
        end
        if (w_fit || !in_sat) begin
            w_result = in_data[OUT_W-1:0];
        end else begin
            w_result = w_satValue;
        end
    end

    // Occupancy state register; in_ready is registered as "skid will be empty".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ     <= OCC_EMPTY;
            r_inReady <= 1'b0;
        end else begin
            r_occ     <= w_occNext;
            r_inReady <= (w_occNext != OCC_TWO);
        end
    end

    // Next occupancy from this cycle's accept and drain.
    always_comb begin
        w_occNext = r_occ;
        case (r_occ)
            OCC_EMPTY: begin
                if (w_accept) begin
                    w_occNext = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (w_accept && !w_drain) begin
                    w_occNext = OCC_TWO;
                end else if (!w_accept && w_drain) begin
                    w_occNext = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (w_drain) begin
                    w_occNext = OCC_ONE;
                end
            end
            default: begin
                w_occNext = OCC_EMPTY;
            end
        endcase
    end

    // Decode which buffer entry loads what for the current occupancy.
    always_comb begin
        w_outValid     = 1'b0;
        w_loadPrimNew  = 1'b0;
        w_loadPrimSkid = 1'b0;
        w_loadSkidNew  = 1'b0;
        case (r_occ)
            OCC_EMPTY: begin
                w_loadPrimNew = w_accept;
            end
            OCC_ONE: begin
                w_outValid    = 1'b1;
                w_loadPrimNew = w_accept & w_drain;
                w_loadSkidNew = w_accept & ~w_drain;
            end
            OCC_TWO: begin
                w_outValid     = 1'b1;
                w_loadPrimSkid = w_drain;
            end
            default: begin
                w_outValid = 1'b0;
            end
        endcase
    end

    // Primary and skid data registers; primary holds steady while stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_primData <= '0;
            r_primFit  <= 1'b0;
            r_skidData <= '0;
            r_skidFit  <= 1'b0;
        end else begin
            if (w_loadPrimNew) begin
                r_primData <= w_result;
                r_primFit  <= w_fit;
            end else if (w_loadPrimSkid) begin
                r_primData <= r_skidData;
                r_primFit  <= r_skidFit;
            end
            if (w_loadSkidNew) begin
                r_skidData <= w_result;
                r_skidFit  <= w_fit;
            end
        end
    end

    // Saturating overflow counter; clear wins but still counts a same-edge event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovfCount <= '0;
        end else if (ovf_clr) begin
            r_ovfCount <= w_countEvent ? CNT_W'(1) : '0;
        end else if (w_countEvent && (r_ovfCount != {CNT_W{1'b1}})) begin
            r_ovfCount <= r_ovfCount + CNT_W'(1);
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = w_outValid;
    assign out_data  = r_primData;
    assign out_fit   = r_primFit;
    assign ovf_count = r_ovfCount;

endmodule

// File: tb/tb_narrow16to5.sv
// tb_narrow16to5: vector table plus directed sequences for narrow16to5,
// with a scoreboard queue of expected results checked at the output.
module tb_narrow16to5;

    typedef struct {
        logic [15:0] data;
        logic        sign;
        logic        sat;
        logic [4:0]  expData;
        logic        expFit;
    } vec_t;

    typedef struct {
        logic [4:0] data;
        logic       fit;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sign;
    logic        in_sat;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_data;
    logic        out_fit;
    logic [7:0]  ovf_count;
    logic        ovf_clr;

    int   testsRun    = 0;
    int   testsFailed = 0;
    exp_t scoreQ[$];
    vec_t vecs[12];

    logic       prevHeld = 1'b0;
    logic [4:0] prevData = '0;
    logic       prevFit  = 1'b0;

    narrow16to5 #(.IN_W(16), .OUT_W(5), .CNT_W(8)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_sign(in_sign),
        .in_sat(in_sat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_fit(out_fit),
        .ovf_count(ovf_count),
        .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model written in terms of integer ranges.
    function automatic exp_t model(input logic [15:0] d, input logic sg, input logic sa);
        exp_t r;
        int   v;
        if (sg) begin
            v     = int'($signed(d));
            r.fit = (v >= -16) && (v <= 15);
        end else begin
            v     = int'(d);
            r.fit = (v <= 31);
        end
        if (r.fit || !sa) r.data = d[4:0];
        else if (sg)      r.data = (v < 0) ? 5'b10000 : 5'b01111;
        else              r.data = 5'b11111;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive one input until accepted (bounded), then record its expected result.
    task automatic applyStimulus(input logic [15:0] d, input logic sg, input logic sa, input exp_t e);
        bit accepted = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_sign  = sg;
        in_sat   = sa;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (accepted) begin
            scoreQ.push_back(e);
        end else begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL accept_timeout: got in_ready=0 for data %0h, expected acceptance", d);
        end
    endtask

    // Output monitor: scoreboard pop on transfer, stability check while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            scoreQ.delete();
            prevHeld = 1'b0;
        end else begin
            if (prevHeld) begin
                checkOutput("stall_stable", {25'd0, out_valid, out_fit, out_data},
                            {25'd0, 1'b1, prevFit, prevData});
            end
            if (out_valid && out_ready) begin
                if (scoreQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL spurious_output: got data %0h fit %0b, expected no output", out_data, out_fit);
                end else begin
                    e = scoreQ.pop_front();
                    checkOutput("result", {26'd0, out_fit, out_data}, {26'd0, e.fit, e.data});
                end
            end
            prevHeld = out_valid && !out_ready;
            prevData = out_data;
            prevFit  = out_fit;
        end
    end

    initial begin
        exp_t e;

        vecs[0]  = '{16'h000F, 1'b1, 1'b0, 5'h0F, 1'b1};
        vecs[1]  = '{16'hFFF0, 1'b1, 1'b0, 5'h10, 1'b1};
        vecs[2]  = '{16'h0010, 1'b1, 1'b1, 5'h0F, 1'b0};
        vecs[3]  = '{16'h8000, 1'b1, 1'b1, 5'h10, 1'b0};
        vecs[4]  = '{16'h0010, 1'b1, 1'b0, 5'h10, 1'b0};
        vecs[5]  = '{16'h001F, 1'b0, 1'b0, 5'h1F, 1'b1};
        vecs[6]  = '{16'h0020, 1'b0, 1'b1, 5'h1F, 1'b0};
        vecs[7]  = '{16'hFFE5, 1'b0, 1'b0, 5'h05, 1'b0};
        vecs[8]  = '{16'hFFFF, 1'b1, 1'b1, 5'h1F, 1'b1};
        vecs[9]  = '{16'h7FFF, 1'b1, 1'b1, 5'h0F, 1'b0};
        vecs[10] = '{16'h0000, 1'b0, 1'b1, 5'h00, 1'b1};
        vecs[11] = '{16'hFFEF, 1'b1, 1'b1, 5'h10, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sign   = 1'b0;
        in_sat    = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_data", out_data, 0);
        checkOutput("reset_out_fit", out_fit, 0);
        checkOutput("reset_ovf_count", ovf_count, 0);
        rst_n = 1'b1;
        #0;
        checkOutput("in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        checkOutput("in_ready_first_edge", in_ready, 1);

        for (int i = 0; i < 12; i++) begin
            e.data = vecs[i].expData;
            e.fit  = vecs[i].expFit;
            applyStimulus(vecs[i].data, vecs[i].sign, vecs[i].sat, e);
            if (i == 0) begin
                checkOutput("first_out_valid", out_valid, 1);
                checkOutput("first_out_data", out_data, 5'h0F);
                checkOutput("first_out_fit", out_fit, 1);
                checkOutput("first_ovf_count", ovf_count, 0);
            end
            if (i == 4) checkOutput("ovf_after_signed", ovf_count, 3);
        end
        checkOutput("ovf_after_table", ovf_count, 7);

        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        e = '{5'd1, 1'b1};
        applyStimulus(16'd1, 1'b0, 1'b0, e);
        e = '{5'd2, 1'b1};
        applyStimulus(16'd2, 1'b0, 1'b0, e);
        in_valid = 1'b1;
        in_data  = 16'd3;
        in_sign  = 1'b0;
        in_sat   = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("bp_in_ready_low", in_ready, 0);
        checkOutput("bp_out_data_head", out_data, 5'd1);
        checkOutput("bp_queue_depth", scoreQ.size(), 2);
        out_ready = 1'b1;
        e = '{5'd3, 1'b1};
        applyStimulus(16'd3, 1'b0, 1'b0, e);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("bp_drained", scoreQ.size(), 0);

        for (int i = 0; i < 300; i++) begin
            logic [15:0] d;
            logic        sg;
            logic        sa;
            d  = 16'h0100 + 16'(i);
            sg = 1'($urandom_range(0, 1));
            sa = 1'($urandom_range(0, 1));
            applyStimulus(d, sg, sa, model(d, sg, sa));
        end
        checkOutput("ovf_saturated", ovf_count, 255);
        ovf_clr = 1'b1;
        applyStimulus(16'h0400, 1'b1, 1'b1, model(16'h0400, 1'b1, 1'b1));
        ovf_clr = 1'b0;
        checkOutput("ovf_clr_with_event", ovf_count, 1);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        checkOutput("ovf_clr_alone", ovf_count, 0);

        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(16'h0015, 1'b0, 1'b0, model(16'h0015, 1'b0, 1'b0));
        applyStimulus(16'h0300, 1'b0, 1'b1, model(16'h0300, 1'b0, 1'b1));
        in_valid = 1'b1;
        in_data  = 16'h0007;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("full_in_ready", in_ready, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_ovf_count", ovf_count, 0);
        checkOutput("midreset_in_ready", in_ready, 0);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("no_stale_result", out_valid, 0);
        checkOutput("ready_after_midreset", in_ready, 1);

        e = '{5'h0F, 1'b1};
        applyStimulus(16'h000F, 1'b1, 1'b0, e);
        for (int k = 0; k < 20 && scoreQ.size() != 0; k++) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", scoreQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
